// File: rtl/imem_loader.sv
// Framed byte-stream loader for instruction memory; holds the CPU in reset until a checksum-verified image is written.
// Write strobe one cycle after a word's 4th byte; done/err one cycle after CHK; rx_ready drops only during the write cycle.
module imem_loader #(
  parameter int         ADDR_W    = 6,
  parameter int         DEPTH     = 64,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         TIMEOUT   = 50000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  output logic              rx_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              cpu_rst_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [7:0]    DEPTH_B  = 8'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERR
  } state_t;

  state_t            state_q;
  logic [7:0]        n_q;
  logic [7:0]        word_q;
  logic [7:0]        chk_q;
  logic [1:0]        byte_q;
  logic [23:0]       asm_q;
  logic [TW-1:0]     tmo_q;
  logic              imem_we_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [31:0]       imem_wdata_q;
  logic              cpu_rst_q;
  logic              done_q;
  logic              err_q;

  logic              xfer_d;
  logic              in_frame_d;
  logic              tmo_hit_d;
  logic [7:0]        word_inc_d;

  assign rx_ready_o = ~rst_i & (state_q != S_WRITE);
  assign xfer_d     = rx_valid_i & rx_ready_o;
  assign in_frame_d = (state_q == S_COUNT) | (state_q == S_DATA) | (state_q == S_CHECK);
  assign tmo_hit_d  = in_frame_d & ~xfer_d & (tmo_q == TMO_LAST);
  assign word_inc_d = word_q + 8'd1;

  assign imem_we_o    = imem_we_q;
  assign imem_addr_o  = imem_addr_q;
  assign imem_wdata_o = imem_wdata_q;
  assign cpu_rst_o    = cpu_rst_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      n_q          <= '0;
      word_q       <= '0;
      chk_q        <= '0;
      byte_q       <= '0;
      asm_q        <= '0;
      tmo_q        <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_rst_q    <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      imem_we_q <= 1'b0;
      if (in_frame_d)
        tmo_q <= xfer_d ? '0 : tmo_q + TW'(1);

      // A stalled frame is abandoned; any half-assembled word is simply dropped.
      if (tmo_hit_d) begin
        state_q <= S_ERR;
        err_q   <= 1'b1;
        tmo_q   <= '0;
      end else begin
        case (state_q)
          S_IDLE, S_DONE, S_ERR: begin
            if (xfer_d && rx_data_i == SYNC_BYTE) begin
              state_q   <= S_COUNT;
              done_q    <= 1'b0;
              err_q     <= 1'b0;
              cpu_rst_q <= 1'b1;
            end
          end
          S_COUNT: begin
            if (xfer_d) begin
              if (rx_data_i == 8'd0 || rx_data_i > DEPTH_B) begin
                state_q <= S_ERR;
                err_q   <= 1'b1;
              end else begin
                state_q <= S_DATA;
                n_q     <= rx_data_i;
                word_q  <= '0;
                byte_q  <= '0;
                chk_q   <= '0;
              end
            end
          end
          S_DATA: begin
            if (xfer_d) begin
              asm_q  <= {asm_q[15:0], rx_data_i};
              chk_q  <= chk_q ^ rx_data_i;
              byte_q <= byte_q + 2'd1;
              if (byte_q == 2'd3) begin
                state_q      <= S_WRITE;
                imem_we_q    <= 1'b1;
                imem_addr_q  <= ADDR_W'(word_q);
                imem_wdata_q <= {asm_q, rx_data_i};
              end
            end
          end
          S_WRITE: begin
            word_q  <= word_inc_d;
            state_q <= (word_inc_d == n_q) ? S_CHECK : S_DATA;
          end
          S_CHECK: begin
            if (xfer_d) begin
              if (rx_data_i == chk_q) begin
                state_q   <= S_DONE;
                done_q    <= 1'b1;
                cpu_rst_q <= 1'b0;
              end else begin
                state_q <= S_ERR;
                err_q   <= 1'b1;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed and random frames against a frame-level model (expected writes, final done/err).
module tb_imem_loader;
  localparam int ADDR_W  = 6;
  localparam int DEPTH   = 64;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst;
  logic              done;
  logic              err;

  int total = 0;
  int bad   = 0;

  logic [7:0]  frame_q[$];
  logic [37:0] exp_q[$];
  logic [37:0] got_q[$];
  logic        exp_done;
  logic        exp_err;

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .SYNC_BYTE(8'hA5), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst), .rx_valid_i(rx_valid), .rx_data_i(rx_data), .rx_ready_o(rx_ready),
    .imem_we_o(imem_we), .imem_addr_o(imem_addr), .imem_wdata_o(imem_wdata),
    .cpu_rst_o(cpu_rst), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Write monitor, plus: outside reset the loader refuses bytes exactly while it strobes a write.
  always @(negedge clk) begin
    if (imem_we === 1'b1) got_q.push_back({imem_addr, imem_wdata});
    if (rst === 1'b0) chk("rdy_vs_we", rx_ready, !imem_we);
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (rx_ready !== 1'b1 && guard < 8) begin @(posedge clk); #1; guard++; end
    chk("rdy_wait", rx_ready, 1'b1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int gapmax);
    foreach (frame_q[i]) begin
      send_byte(frame_q[i]);
      if (gapmax > 0) idle($urandom_range(0, gapmax));
    end
  endtask

  // mode 0: good frame, 1: corrupted checksum, 2: illegal count (n supplied by caller)
  task automatic build_rand(input int n, input int mode);
    logic [31:0] w;
    logic [7:0]  x;
    frame_q.delete();
    exp_q.delete();
    frame_q.push_back(8'hA5);
    frame_q.push_back(8'(n));
    exp_done = (mode == 0);
    exp_err  = (mode != 0);
    if (mode == 2) return;
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      for (int k = 3; k >= 0; k--) begin
        frame_q.push_back(w[8*k +: 8]);
        x = x ^ w[8*k +: 8];
      end
      exp_q.push_back({6'(i), w});
    end
    if (mode == 1) x = x ^ 8'($urandom_range(1, 255));
    frame_q.push_back(x);
  endtask

  task automatic check_result(input string tag);
    int m;
    idle(2);
    chk({tag, "_nwr"}, got_q.size(), exp_q.size());
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) chk({tag, "_wr"}, got_q[i], exp_q[i]);
    chk({tag, "_done"}, done, exp_done);
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_cpurst"}, cpu_rst, !exp_done);
    got_q.delete();
  endtask

  initial begin
    int mode;
    int n;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    idle(2);
    chk("rst_cpurst", cpu_rst, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_we", imem_we, 1'b0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_rdy", rx_ready, 1'b0);
    rst = 1'b0;
    idle(1);
    chk("idle_rdy", rx_ready, 1'b1);

    frame_q = '{8'hA5, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h08, 8'h40, 8'h20, 8'h44};
    exp_q   = '{{6'd0, 32'h20080005}, {6'd1, 32'h01084020}};
    exp_done = 1'b1; exp_err = 1'b0;
    send_frame(2);
    check_result("t1");

    frame_q = '{8'h00, 8'h37, 8'h5A};
    send_frame(1);
    chk("sticky_done", done, 1'b1);
    chk("sticky_nwr", got_q.size(), 0);

    frame_q = '{8'hA5, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h08, 8'h40, 8'h20, 8'h45};
    exp_done = 1'b0; exp_err = 1'b1;
    send_frame(1);
    check_result("t2_badchk");

    frame_q = '{8'hA5, 8'h00};
    exp_q.delete();
    send_frame(0);
    check_result("t3_n0");
    frame_q = '{8'hA5, 8'h41};
    send_frame(0);
    check_result("t3_n65");

    frame_q = '{8'hA5, 8'h01, 8'hDE, 8'hAD, 8'hBE};
    send_frame(0);
    chk("tmo_errclr", err, 1'b0);
    idle(TIMEOUT - 1);
    chk("tmo_early", err, 1'b0);
    idle(1);
    chk("tmo_err", err, 1'b1);
    chk("tmo_cpurst", cpu_rst, 1'b1);
    chk("tmo_nwr", got_q.size(), 0);
    got_q.delete();

    frame_q = '{8'hA5, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    exp_q   = '{{6'd0, 32'hDEADBEEF}};
    exp_done = 1'b1; exp_err = 1'b0;
    send_frame(3);
    check_result("t5_reload");

    frame_q = '{8'h00, 8'hFF, 8'h13, 8'hA5, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                8'h01, 8'h08, 8'h40, 8'h20, 8'h44};
    exp_q   = '{{6'd0, 32'h20080005}, {6'd1, 32'h01084020}};
    send_frame(1);
    check_result("t4_garbage");

    build_rand(5, 0);
    send_frame(0);
    check_result("held_valid");

    build_rand(DEPTH, 0);
    send_frame(0);
    check_result("max_depth");

    frame_q = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33};
    send_frame(0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_cpurst", cpu_rst, 1'b1);
    chk("midrst_done", done, 1'b0);
    chk("midrst_err", err, 1'b0);
    chk("midrst_rdy", rx_ready, 1'b0);
    rst = 1'b0;
    idle(1);
    chk("midrst_nwr", got_q.size(), 0);
    got_q.delete();
    build_rand(3, 0);
    send_frame(2);
    check_result("after_rst");

    for (int it = 0; it < 10; it++) begin
      mode = $urandom_range(0, 2);
      if (mode == 2) n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(DEPTH + 1, 255);
      else           n = $urandom_range(1, 8);
      build_rand(n, mode);
      send_frame($urandom_range(0, 3));
      check_result("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
